// File: rtl/mipi_csi2_depack.sv
// CSI-2 packet depacketizer: parses headers, unpacks RAW8/10/12 payloads into
// MSB-justified pixels, checks payload CRC-16 and tracks line/frame counters.
module mipi_csi2_depack #(
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                  img_clk,
    input  logic                  resetb,
    input  logic                  enable,
    input  logic [7:0]            phy_data,
    input  logic                  phy_we,
    input  logic                  phy_dvo,
    input  logic [1:0]            vc_sel,
    output logic [DATA_WIDTH-1:0] dato,
    output logic                  dvo,
    output logic                  lvo,
    output logic                  fvo,
    output logic [5:0]            pkt_dt,
    output logic [15:0]           line_cnt,
    output logic [15:0]           frame_cnt,
    output logic                  crc_err,
    output logic                  trunc_err,
    output logic                  unsup_dt
);
    localparam int unsigned PW = 12;
    localparam logic [5:0]  DT_FS    = 6'h00;
    localparam logic [5:0]  DT_FE    = 6'h01;
    localparam logic [5:0]  DT_RAW8  = 6'h2A;
    localparam logic [5:0]  DT_RAW10 = 6'h2B;
    localparam logic [5:0]  DT_RAW12 = 6'h2C;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h8408;

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_CRC, S_EOT} state_t;
    state_t state, state_nxt;

    logic [1:0]           vc;
    logic [5:0]           dt;
    logic [1:0]           hdr_cnt;
    logic [15:0]          wc;
    logic [15:0]          crc;
    logic [7:0]           ftr_lo;
    logic                 ftr_cnt;
    logic [3:0][7:0]      grp;
    logic [2:0]           grp_idx;
    logic [2:0][PW-1:0]   pend;
    logic [1:0]           drain_rem;
    logic                 pay_done;

    logic                 vc_ok_c, is_long_c;
    logic                 di_c, hdr_byte_c, dec_c, pay_byte_c, ftr_byte_c, trunc_c;
    logic                 grp_done_c;
    logic [2:0]           grp_len_c, npx_c;
    logic [3:0][PW-1:0]   px_c;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] justify(input logic [PW-1:0] p);
        return DATA_WIDTH'(p) << (DATA_WIDTH - PW);
    endfunction

    // State register
    always_ff @(posedge img_clk or negedge resetb) begin
        if (!resetb) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next state and per-cycle byte strobes
    always_comb begin
        state_nxt  = state;
        di_c       = 1'b0;
        hdr_byte_c = 1'b0;
        dec_c      = 1'b0;
        pay_byte_c = 1'b0;
        ftr_byte_c = 1'b0;
        trunc_c    = 1'b0;
        vc_ok_c    = (vc == vc_sel);
        is_long_c  = (dt == DT_RAW8) || (dt == DT_RAW10) || (dt == DT_RAW12);
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (phy_we && phy_dvo) begin
                        di_c      = 1'b1;
                        state_nxt = S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (!phy_we) begin
                        trunc_c   = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (phy_dvo) begin
                        hdr_byte_c = 1'b1;
                        if (hdr_cnt == 2'd2) begin
                            dec_c = 1'b1;
                            if (vc_ok_c && is_long_c)
                                state_nxt = (wc == 16'd0) ? S_CRC : S_PAYLOAD;
                            else
                                state_nxt = S_EOT;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (!phy_we) begin
                        trunc_c   = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (phy_dvo) begin
                        pay_byte_c = 1'b1;
                        if (wc == 16'd1) state_nxt = S_CRC;
                    end
                end
                S_CRC: begin
                    if (!phy_we) begin
                        trunc_c   = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (phy_dvo) begin
                        ftr_byte_c = 1'b1;
                        if (ftr_cnt) state_nxt = S_EOT;
                    end
                end
                S_EOT: begin
                    if (!phy_we) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Group unpacking; the current byte is always the last byte of the group
    always_comb begin
        px_c      = '0;
        grp_len_c = 3'd1;
        npx_c     = 3'd1;
        case (pkt_dt)
            DT_RAW10: begin
                grp_len_c = 3'd5;
                npx_c     = 3'd4;
                for (int i = 0; i < 4; i++)
                    px_c[i] = {grp[i], phy_data[2*i +: 2], 2'b00};
            end
            DT_RAW12: begin
                grp_len_c = 3'd3;
                npx_c     = 3'd2;
                px_c[0]   = {grp[0], phy_data[3:0]};
                px_c[1]   = {grp[1], phy_data[7:4]};
            end
            default: px_c[0] = {phy_data, 4'h0};
        endcase
        grp_done_c = pay_byte_c && (grp_idx == grp_len_c - 3'd1);
    end

    // Datapath, pixel drain and status outputs
    always_ff @(posedge img_clk or negedge resetb) begin
        if (!resetb) begin
            dato      <= '0;
            dvo       <= 1'b0;
            lvo       <= 1'b0;
            fvo       <= 1'b0;
            pkt_dt    <= '0;
            line_cnt  <= '0;
            frame_cnt <= '0;
            crc_err   <= 1'b0;
            trunc_err <= 1'b0;
            unsup_dt  <= 1'b0;
            vc        <= '0;
            dt        <= '0;
            hdr_cnt   <= '0;
            wc        <= '0;
            crc       <= '0;
            ftr_lo    <= '0;
            ftr_cnt   <= 1'b0;
            grp       <= '0;
            grp_idx   <= '0;
            pend      <= '0;
            drain_rem <= '0;
            pay_done  <= 1'b0;
        end else begin
            crc_err   <= 1'b0;
            trunc_err <= 1'b0;
            unsup_dt  <= 1'b0;

            if (drain_rem != 2'd0) begin
                dato      <= justify(pend[0]);
                dvo       <= 1'b1;
                pend      <= {PW'(0), pend[2], pend[1]};
                drain_rem <= drain_rem - 2'd1;
            end else begin
                dvo <= 1'b0;
                if (lvo && pay_done) begin
                    lvo      <= 1'b0;
                    pay_done <= 1'b0;
                    line_cnt <= line_cnt + 16'd1;
                end
            end

            if (di_c) begin
                vc      <= phy_data[7:6];
                dt      <= phy_data[5:0];
                hdr_cnt <= 2'd0;
            end

            if (hdr_byte_c) begin
                hdr_cnt <= hdr_cnt + 2'd1;
                if (hdr_cnt == 2'd0)      wc[7:0]  <= phy_data;
                else if (hdr_cnt == 2'd1) wc[15:8] <= phy_data;
            end

            if (dec_c && vc_ok_c) begin
                if (dt == DT_FS) begin
                    fvo      <= 1'b1;
                    line_cnt <= 16'd0;
                end else if (dt == DT_FE) begin
                    fvo       <= 1'b0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else if (is_long_c) begin
                    pkt_dt   <= dt;
                    crc      <= CRC_INIT;
                    grp_idx  <= 3'd0;
                    ftr_cnt  <= 1'b0;
                    pay_done <= 1'b0;
                end else if (dt >= 6'h10) begin
                    unsup_dt <= 1'b1;
                end
            end

            if (pay_byte_c) begin
                wc  <= wc - 16'd1;
                crc <= crc_step(crc, phy_data);
                if (grp_done_c) begin
                    grp_idx <= 3'd0;
                end else begin
                    grp[grp_idx[1:0]] <= phy_data;
                    grp_idx           <= grp_idx + 3'd1;
                end
                if (wc == 16'd1) pay_done <= 1'b1;
            end

            if (grp_done_c) begin
                dato      <= justify(px_c[0]);
                dvo       <= 1'b1;
                lvo       <= 1'b1;
                pend      <= {px_c[3], px_c[2], px_c[1]};
                drain_rem <= 2'(npx_c - 3'd1);
            end

            // Footer arrives LSB first
            if (ftr_byte_c) begin
                ftr_cnt <= 1'b1;
                ftr_lo  <= phy_data;
                if (ftr_cnt) crc_err <= ({phy_data, ftr_lo} != crc);
            end

            if (trunc_c) begin
                trunc_err <= 1'b1;
                drain_rem <= 2'd0;
                dvo       <= 1'b0;
                lvo       <= 1'b0;
                pay_done  <= 1'b0;
            end

            if (!enable) begin
                dvo       <= 1'b0;
                lvo       <= 1'b0;
                fvo       <= 1'b0;
                drain_rem <= 2'd0;
                pay_done  <= 1'b0;
            end
        end
    end

endmodule
